wav_sel_n: RTL and testbench
============================

# wav_sel_n

Parametrised waveform selector for the synthesizer voice path. It takes NUM_WAVES unsigned sample streams from the lookup-table oscillators and presents one of them, registered, to the R2R DAC driver. The selection is stepped by synchronised, edge-detected inc/dec button presses or loaded directly from a selection bus. An optional linear crossfade removes clicks when the selection changes.

## Interface
Parameters:
- NUM_WAVES, 4: number of input waveforms, 2..16.
- WIDTH, 8: sample width in bits, unsigned.
- SEL_W, 2: selection index width; must equal clog2(NUM_WAVES).
- XFADE_LOG2, 4: crossfade length is 2^XFADE_LOG2 sample strobes; 1..8.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- wav_in  in  NUM_WAVES*WIDTH  packed samples; channel i is at bits [i*WIDTH +: WIDTH].
- sample_en  in  1  one-clk strobe per audio sample; advances the crossfade.
- inc  in  1  asynchronous button level; step selection up.
- dec  in  1  asynchronous button level; step selection down.
- load  in  1  synchronous strobe; load load_sel directly.
- load_sel  in  SEL_W  direct selection index.
- wav  out  WIDTH  registered output sample.
- sel  out  SEL_W  current (target) selection index.
- busy  out  1  high while a crossfade is in progress.

## Operation
- Reset: sel=0, wav=0, busy=0, FSM in IDLE, all synchroniser/edge flops cleared. A button already held at reset release counts as one press.
- inc and dec each pass through a 2-flop synchroniser and then a rising-edge detector. Exactly one step is taken per press; holding a button has no further effect.
- Step rules:
  - inc: sel = (sel == NUM_WAVES-1) ? 0 : sel+1.
  - dec: sel = (sel == 0) ? NUM_WAVES-1 : sel-1.
  - Simultaneous inc and dec edges in the same cycle: both are ignored.
- Direct load:
  - load has priority over inc/dec edges in the same cycle.
  - load_sel >= NUM_WAVES is ignored.
  - load_sel == sel causes no change and no fade.
- A selection change is a request. Requests arriving while busy=1 are dropped (not queued).
- FSM without the crossfade feature: a single state, IDLE. wav <= wav_in[sel] every clk.
- FSM with the crossfade feature:
  - IDLE: wav <= wav_in[sel]. A request sets old_sel = previous sel, updates sel, clears k=0, sets busy=1, and moves to FADE.
  - FADE: wav <= (A*(2^L - k) + B*k) >> L every clk, where A = wav_in[old_sel], B = wav_in[sel], L = XFADE_LOG2. All arithmetic is unsigned with an intermediate width of WIDTH+L+1; the result is truncated, not rounded.
  - Each sample_en in FADE increments k. On the sample_en where k == 2^L-1: return to IDLE, busy=0; from the next clk, wav = B exactly.
  - k=0 yields exactly A. No overflow is possible: the weights sum to 2^L.
- Reset mid-fade: immediate return to IDLE with reset values.

## Timing
- Sample path: wav_in to wav is 1 clk of latency in both IDLE and FADE.
- Button path: inc is first high at clk edge 0 → sync stage 1 at edge 1, stage 2 at edge 2 → sel updated at edge 3 → wav from the new channel (or the fade start) at edge 4.
- Load path: load sampled at edge 0 → sel updated at edge 0 → wav reflects the change at edge 1.
- busy rises on the same edge as sel changes. It falls on the edge that consumes the final sample_en of the fade.
- Fade duration: exactly 2^XFADE_LOG2 sample_en strobes, independent of strobe spacing.
- sample_en in IDLE has no effect.

## Configuration
- WAV_SEL_N_XFADE_EN defined: crossfade FSM, old_sel/k registers, weighted mix and busy logic are compiled in, as described above.
- WAV_SEL_N_XFADE_EN undefined: no mixer. Selection changes switch wav on the next clk. busy is tied to 0 and never drops requests. XFADE_LOG2 is unused.

## Test plan
- Reset, then hold inc high for 20 clks with NUM_WAVES=4 → sel goes 0→1 exactly once, at the 3rd edge; wav = wav_in[1] at the 4th edge.
- Four inc presses then one dec press from sel=0 → sel sequence 1,2,3,0,3 (wrap both ways); inc and dec edges in the same cycle → sel unchanged.
- load=1 with load_sel=2 in the same cycle as an inc edge → sel=2. Then load_sel=5 with NUM_WAVES=4 → ignored. Then load_sel=2 → no change, busy stays 0.
- XFADE_EN, L=2, channel 0 constant 200, channel 1 constant 40, load to 1 → wav = 200, 160, 120, 80 across sample_en strobes, then 40; busy high for exactly 4 strobes; an inc press during the fade is dropped.
- Assert rst mid-fade → wav=0, sel=0, busy=0 immediately (asynchronously). After release, wav follows wav_in[0] one clk behind.
- XFADE_EN undefined, load to 3 → wav = wav_in[3] on the next clk; busy stays 0 throughout.

Source files
------------

// File: rtl/wav_sel_n.sv
// wav_sel_n: registers one of NUM_WAVES sample streams toward the DAC, stepped by inc/dec
// buttons or loaded directly. Define WAV_SEL_N_XFADE_EN to compile in the linear crossfade.
module wav_sel_n #(
  parameter int NUM_WAVES  = 4,
  parameter int WIDTH      = 8,
  parameter int SEL_W      = 2,
  parameter int XFADE_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WAVES*WIDTH-1:0] wav_in,
  input  logic                       sample_en,
  input  logic                       inc,
  input  logic                       dec,
  input  logic                       load,
  input  logic [SEL_W-1:0]           load_sel,
  output logic [WIDTH-1:0]           wav,
  output logic [SEL_W-1:0]           sel,
  output logic                       busy
);

  if (SEL_W != $clog2(NUM_WAVES)) begin : g_bad_sel_w
    $error("wav_sel_n: SEL_W must equal clog2(NUM_WAVES)");
  end
  if (NUM_WAVES < 2 || NUM_WAVES > 16 || XFADE_LOG2 < 1 || XFADE_LOG2 > 8) begin : g_bad_range
    $error("wav_sel_n: NUM_WAVES or XFADE_LOG2 out of range");
  end

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_WAVES - 1);

  // Bit 0 tracks inc, bit 1 tracks dec through the synchroniser and edge detector.
  logic [1:0]       btn_s1_q, btn_s1_d;
  logic [1:0]       btn_s2_q, btn_s2_d;
  logic [1:0]       btn_prev_q, btn_prev_d;
  logic             inc_edge, dec_edge;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] wav_q, wav_d;
  logic [WIDTH-1:0] cur_smp;
  logic             req;
  logic [SEL_W-1:0] req_sel;

  always_comb begin
    btn_s1_d   = {dec, inc};
    btn_s2_d   = btn_s1_q;
    btn_prev_d = btn_s2_q;
    inc_edge   = btn_s2_q[0] & ~btn_prev_q[0];
    dec_edge   = btn_s2_q[1] & ~btn_prev_q[1];
  end

  assign cur_smp = wav_in[int'(sel_q)*WIDTH +: WIDTH];

  // A load strobe owns the cycle even when its index is rejected; button edges are discarded.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    req     = 1'b0;
    req_sel = sel_q;
    if (load) begin
      if ((int'(load_sel) < NUM_WAVES) && (load_sel != sel_q)) begin
        req     = 1'b1;
        req_sel = load_sel;
      end
    end else if (inc_edge && !dec_edge) begin
      req     = 1'b1;
      req_sel = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
    end else if (dec_edge && !inc_edge) begin
      req     = 1'b1;
      req_sel = (sel_q == '0) ? LAST_SEL : sel_q - 1'b1;
    end
  end

`ifdef WAV_SEL_N_XFADE_EN
  localparam int                    MIX_W  = WIDTH + XFADE_LOG2 + 1;
  localparam logic [XFADE_LOG2-1:0] K_LAST = '1;

  typedef enum logic {ST_IDLE, ST_FADE} state_e;

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      old_sel_q, old_sel_d;
  logic [XFADE_LOG2-1:0] k_q, k_d;
  logic [WIDTH-1:0]      old_smp;
  logic [MIX_W-1:0]      mix_sum;
  logic [WIDTH-1:0]      mix_smp;

  assign old_smp = wav_in[int'(old_sel_q)*WIDTH +: WIDTH];

  // Weights sum to 2^L, so the sum fits WIDTH+L bits and the shift truncates.
  assign mix_sum = MIX_W'(old_smp) * ((MIX_W'(1) << XFADE_LOG2) - MIX_W'(k_q))
                 + MIX_W'(cur_smp) * MIX_W'(k_q);
  assign mix_smp = WIDTH'(mix_sum >> XFADE_LOG2);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    old_sel_d = old_sel_q;
    k_d       = k_q;
    wav_d     = cur_smp;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          old_sel_d = sel_q;
          sel_d     = req_sel;
          k_d       = '0;
          state_d   = ST_FADE;
        end
      end
      ST_FADE: begin
        wav_d = mix_smp;
        if (sample_en) begin
          k_d = k_q + 1'b1;
          if (k_q == K_LAST) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      old_sel_q <= '0;
      k_q       <= '0;
    end else begin
      state_q   <= state_d;
      old_sel_q <= old_sel_d;
      k_q       <= k_d;
    end
  end

  assign busy = (state_q == ST_FADE);
`else
  logic unused_sample_en;

  always_comb begin
    sel_d = req ? req_sel : sel_q;
    wav_d = cur_smp;
  end

  assign busy             = 1'b0;
  assign unused_sample_en = sample_en;
`endif

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state flops use non-blocking assignment and an async reset so every flop sees pre-edge values.
    if (rst) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_prev_q <= '0;
      sel_q      <= '0;
      wav_q      <= '0;
    end else begin
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      btn_prev_q <= btn_prev_d;
      sel_q      <= sel_d;
      wav_q      <= wav_d;
    end
  end

  assign wav = wav_q;
  assign sel = sel_q;

endmodule

// File: tb/tb_wav_sel_n.sv
// Scoreboard bench for wav_sel_n: a spec-level model queues the expected outputs per edge
// and a monitor pops and compares them; async reset values are checked by the same monitor.
module tb_wav_sel_n;
  localparam int NW     = 5;
  localparam int W      = 8;
  localparam int SEL_W  = 3;
  localparam int L      = 2;
  localparam int FADE_N = 1 << L;
`ifdef WAV_SEL_N_XFADE_EN
  localparam bit XF = 1'b1;
`else
  localparam bit XF = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0]     wav;
    logic [SEL_W-1:0] sel;
    logic             busy;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NW*W-1:0]   wav_in;
  logic              sample_en, inc, dec, load;
  logic [SEL_W-1:0]  load_sel;
  logic [W-1:0]      wav;
  logic [SEL_W-1:0]  sel;
  logic              busy;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: selection, fade bookkeeping and button level history
  int chan_val [NW];
  int m_sel, m_old, m_k;
  bit m_fading;
  bit inc_h [1:3];
  bit dec_h [1:3];

  wav_sel_n #(.NUM_WAVES(NW), .WIDTH(W), .SEL_W(SEL_W), .XFADE_LOG2(L)) dut (
    .clk(clk), .rst(rst), .wav_in(wav_in), .sample_en(sample_en), .inc(inc), .dec(dec),
    .load(load), .load_sel(load_sel), .wav(wav), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: reset values whenever rst is high, otherwise one queued expectation per edge
  always @(posedge clk or posedge rst) begin
    exp_t e;
    #1;
    if (rst) begin
      n_vec++;
      if (wav !== '0 || sel !== '0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset: wav=%0d sel=%0d busy=%b, required 0 0 0", wav, sel, busy);
      end
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (wav !== e.wav || sel !== e.sel || busy !== e.busy) begin
        n_err++;
        $display("FAIL vec%0d @%0t: wav=%0d sel=%0d busy=%b, required wav=%0d sel=%0d busy=%b",
                 n_vec, $time, wav, sel, busy, e.wav, e.sel, e.busy);
      end
    end
  end

  task automatic model_reset();
    m_sel = 0; m_old = 0; m_k = 0; m_fading = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      inc_h[j] = 1'b0;
      dec_h[j] = 1'b0;
    end
  endtask

  // One clock edge of the model; a press is seen when the level two edges ago is high and three edges ago low
  task automatic model_step(input bit i, input bit d, input bit ld, input int ls, input bit se);
    exp_t e;
    bit   pi, pd, req;
    int   nxt;
    pi = inc_h[2] && !inc_h[3];
    pd = dec_h[2] && !dec_h[3];
    if (m_fading)
      e.wav = W'((chan_val[m_old] * (FADE_N - m_k) + chan_val[m_sel] * m_k) / FADE_N);
    else
      e.wav = W'(chan_val[m_sel]);
    req = 1'b0;
    nxt = m_sel;
    if (ld) begin
      if (ls < NW && ls != m_sel) begin req = 1'b1; nxt = ls; end
    end else if (pi && !pd) begin
      req = 1'b1; nxt = (m_sel + 1) % NW;
    end else if (pd && !pi) begin
      req = 1'b1; nxt = (m_sel + NW - 1) % NW;
    end
    if (m_fading) begin
      if (se) begin
        m_k++;
        if (m_k == FADE_N) m_fading = 1'b0;
      end
    end else if (req) begin
      m_old = m_sel; m_sel = nxt; m_k = 0; m_fading = XF;
    end
    e.sel  = SEL_W'(m_sel);
    e.busy = m_fading;
    sb.push_back(e);
    inc_h[3] = inc_h[2]; inc_h[2] = inc_h[1]; inc_h[1] = i;
    dec_h[3] = dec_h[2]; dec_h[2] = dec_h[1]; dec_h[1] = d;
  endtask

  task automatic apply(input bit i, input bit d, input bit ld, input int ls, input bit se);
    inc = i; dec = d; load = ld; load_sel = SEL_W'(ls); sample_en = se;
    for (int c = 0; c < NW; c++) wav_in[c*W +: W] = W'(chan_val[c]);
    model_step(i, d, ld, ls, se);
  endtask

  task automatic cycle(input bit i, input bit d, input bit ld, input int ls, input bit se);
    @(negedge clk);
    apply(i, d, ld, ls, se);
  endtask

  task automatic press(input bit i, input bit d);
    repeat (4) cycle(i, d, 1'b0, 0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    bit ri, rd;
    ri = 1'b0; rd = 1'b0;
    rst = 1'b1;
    inc = 1'b1; dec = 1'b0; load = 1'b0; load_sel = '0; sample_en = 1'b0; wav_in = '0;
    chan_val[0] = 200; chan_val[1] = 40; chan_val[2] = 17; chan_val[3] = 255; chan_val[4] = 99;
    model_reset();

    // inc held across reset release and for 20 clks: exactly one step
    repeat (3) @(negedge clk);
    rst = 1'b0;
    apply(1'b1, 1'b0, 1'b0, 0, 1'b0);
    repeat (19) cycle(1'b1, 1'b0, 1'b0, 0, 1'b1);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 0, 1'b1);

    // Back to 0, then wrap up through NUM_WAVES-1 to 0 and down again
    cycle(1'b0, 1'b0, 1'b1, 0, 1'b1);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 0, 1'b1);
    repeat (NW) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);

    // Load beats an inc edge in the same cycle, then out-of-range and same-index loads
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 2, 1'b1);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 7, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 5, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 2, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Fade 200 -> 40 with spaced strobes and an inc press that lands while busy
    cycle(1'b0, 1'b0, 1'b1, 0, 1'b1);
    repeat (6) cycle(1'b0, 1'b0, 1'b0, 0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1, 1'b0);
    for (int s = 0; s < 6; s++) begin
      cycle(s == 1, 1'b0, 1'b0, 0, 1'b0);
      cycle(s == 1, 1'b0, 1'b0, 0, 1'b0);
      cycle(s == 1, 1'b0, 1'b0, 0, 1'b1);
    end

    // Reset in the middle of a fade, then wav tracks channel 0
    cycle(1'b0, 1'b0, 1'b1, 3, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 0, 1'b1);
    mid_reset();
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < NW; c++) chan_val[c] = $urandom_range(0, 255);
      cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);
    end

    // Random buttons, loads, strobes and samples, with one reset partway through
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) mid_reset();
      if ($urandom_range(0, 9) == 0) ri = !ri;
      if ($urandom_range(0, 11) == 0) rd = !rd;
      for (int c = 0; c < NW; c++) chan_val[c] = $urandom_range(0, 255);
      cycle(ri, rd, $urandom_range(0, 9) == 0, $urandom_range(0, 7), $urandom_range(0, 2) == 0);
    end

    repeat (2) @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
